// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: states, opcodes,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Operation class handed to the ALU decoder.
  localparam logic [1:0] CLS_ADD = 2'd0;
  localparam logic [1:0] CLS_R   = 2'd1;
  localparam logic [1:0] CLS_I   = 2'd2;

  localparam logic [1:0] A_RS1   = 2'd0;
  localparam logic [1:0] A_PC    = 2'd1;
  localparam logic [1:0] A_ZERO  = 2'd2;
  localparam logic       B_RS2   = 1'b0;
  localparam logic       B_IMM   = 1'b1;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_ALU     = 2'd1;
  localparam logic [1:0] PC_ALU_B0  = 2'd2;
  localparam logic       ADDR_PC  = 1'b0;
  localparam logic       ADDR_ALU = 1'b1;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational ALU operation decoder: maps the instruction's operation class
// and funct fields to an alu_op code.
module alu_dec
  import ctrl_pkg::*;
(
  input  logic [1:0] cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_op
);

  always_comb begin
    // NOTE: default first so every path assigns alu_op and no latch is inferred.
    alu_op = ALU_ADD;
    if (cls != CLS_ADD) begin
      case (funct3)
        3'b000:  alu_op = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback and drives all datapath enables and selects.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter state_t RESET_STATE     = FETCH,
  parameter bit     TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       ir_we,
  output logic [1:0] alu_a_sel,
  output logic       alu_b_sel,
  output logic [3:0] alu_op,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       instr_done,
  output logic       illegal,
  output logic [2:0] state
);

  state_t     state_q, state_d;
  logic       illegal_q, set_illegal;
  logic [1:0] cls;
  logic [3:0] dec_op;
  logic [1:0] a_sel;
  logic       b_sel;

  // ALU operands depend only on the IR, so they stay stable from EXEC through WB.
  always_comb begin
    cls   = CLS_ADD;
    a_sel = A_RS1;
    b_sel = B_IMM;
    case (opcode)
      OP_R:                        begin cls = CLS_R; b_sel = B_RS2; end
      OP_IMM:                      cls   = CLS_I;
      OP_LUI:                      a_sel = A_ZERO;
      OP_AUIPC, OP_BRANCH, OP_JAL: a_sel = A_PC;
      default: ;
    endcase
  end

  alu_dec u_alu_dec (
    .cls      (cls),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_op   (dec_op)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
      state_q <= state_d;
      if (set_illegal) illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    set_illegal  = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_PC;
    ir_we        = 1'b0;
    alu_a_sel    = A_RS1;
    alu_b_sel    = B_RS2;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    wb_sel       = WB_ALU;
    pc_we        = 1'b0;
    pc_sel       = PC_PLUS4;
    instr_done   = 1'b0;

    case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_legal(opcode)) begin
          state_d = EXEC;
        end else begin
          set_illegal = 1'b1;
          if (TRAP_ON_ILLEGAL) begin
            state_d = TRAP;
          end else begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      EXEC: begin
        alu_a_sel = a_sel;
        alu_b_sel = b_sel;
        alu_op    = dec_op;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_BRANCH: begin
            pc_we      = 1'b1;
            pc_sel     = br_taken ? PC_ALU : PC_PLUS4;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
          OP_JAL, OP_JALR: begin
            reg_we     = 1'b1;
            wb_sel     = WB_PC4;
            pc_we      = 1'b1;
            pc_sel     = (opcode == OP_JAL) ? PC_ALU : PC_ALU_B0;
            instr_done = 1'b1;
            state_d    = FETCH;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        alu_a_sel    = a_sel;
        alu_b_sel    = b_sel;
        alu_op       = dec_op;
        mem_req      = 1'b1;
        mem_addr_sel = ADDR_ALU;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        alu_a_sel  = a_sel;
        alu_b_sel  = b_sel;
        alu_op     = dec_op;
        reg_we     = 1'b1;
        wb_sel     = (opcode == OP_LOAD) ? WB_MEM : WB_ALU;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase

    // Reset silences the datapath immediately, even before the state settles.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      alu_a_sel    = 2'd0;
      alu_b_sel    = 1'b0;
      alu_op       = 4'd0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      pc_we        = 1'b0;
      pc_sel       = 2'd0;
      instr_done   = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
